decode_stage_pipelined: RTL and testbench
=========================================

Name: decode_stage_pipelined

Overview:
Parametrised, registered instruction-decode stage for the pipelined core. It combines opcode decode, a configurable-depth register file with write-through bypass, sign extension and an ID/EX output register. Valid/ready handshakes connect it to IF/ID upstream and EX downstream. It adds load-use hazard detection with configurable bubble insertion, a synchronous flush and illegal-opcode flagging.

Parameters:
WORD_W, 32, data/register width in bits; must be >= 16.
NUM_REGS, 32, register count; power of 2, 2..32.
REG_AW, $clog2(NUM_REGS), register index width; derived, not overridden.
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes.
LU_BUBBLES, 1, bubbles inserted per load-use hazard; valid range 1..7.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  IF/ID holds a valid instruction
in_ready  out  1  stage accepts instruction this cycle
instruction  in  32  instruction word; fixed 32-bit format
pc_in  in  WORD_W  PC accompanying instruction
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  EX accepts ID/EX contents
flush  in  1  synchronous kill of ID/EX contents and pending bubbles
wb_en  in  1  register-file write enable
wb_addr  in  REG_AW  write register index
wb_data  in  WORD_W  write data
ex_ctrl  out  4  {RegDst, ALUSrc, ALUOp1, ALUOp0}
mem_ctrl  out  3  {MemRead, MemWrite, Branch}
wb_ctrl  out  2  {RegWrite, MemtoReg}
pc_out  out  WORD_W  registered PC
rd_data1  out  WORD_W  registered value of rs
rd_data2  out  WORD_W  registered value of rt
imm_ext  out  WORD_W  registered sign-extended instruction[15:0]
rs_out, rt_out, rd_out  out  REG_AW each  registered register indices
illegal_op  out  1  registered; opcode not recognised
hazard_stall  out  1  combinational; load-use hold active

Behaviour:
- Reset (rst=0, async):
  - all register-file entries, all ID/EX outputs and the bubble counter go to 0.
  - out_valid=0, in_ready=0 while rst low.
  - Reset mid-transfer discards the transfer.
- Field extraction:
  - opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
  - Register indices use the low REG_AW bits; upper bits are ignored.
- Decode:
  - 0x00 R-type: ex=1010, mem=000, wb=10.
  - 0x23 lw: ex=0100, mem=100, wb=11.
  - 0x2B sw: ex=0100, mem=010, wb=00.
  - 0x04 beq: ex=0001, mem=001, wb=00.
  - Any other opcode: all control 0, illegal_op=1; the instruction still flows with out_valid=1.
- Register file:
  - One write port, written on the rising edge when wb_en=1.
  - With ZERO_REG=1, writes to index 0 are dropped and reads of index 0 return 0.
  - Bypass: when wb_en=1 and wb_addr matches a read index in the same cycle (and the index is not zero-forced), the read returns wb_data.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = rst & advance & ~hazard_stall & (bubble_cnt==0).
  - in_fire = in_valid & in_ready.
  - On advance: out_valid <= in_fire & ~flush, and all data/ctrl outputs load from decode when in_fire.
  - Without advance, outputs hold stable; out_valid must not drop without out_ready.
- Load-use hazard: hazard_stall=1 when all of the following hold:
  - out_valid=1 and mem_ctrl[2]=1 (lw in ID/EX);
  - in_valid=1;
  - rt_out is non-zero (or ZERO_REG=0);
  - rt_out equals the incoming rs, or equals the incoming rt when the incoming opcode is R-type, sw or beq.
- Bubble counter:
  - When the hazard lw advances out (out_ready=1, hazard_stall=1), the resulting bubble is the first. bubble_cnt loads LU_BUBBLES-1.
  - While bubble_cnt>0: in_ready=0, and bubble_cnt decrements by 1 each cycle.
  - Total dead cycles seen by EX = LU_BUBBLES.
- Flush:
  - flush=1 forces out_valid<=0 and bubble_cnt<=0 on the next edge regardless of advance.
  - Sets in_ready=0 that cycle, so no instruction is accepted.
  - flush has priority over hazard and over in_fire.
- Simultaneous events:
  - wb write and decode read of the same register in the same cycle: the bypass value is registered.
  - out_ready=0 with a pending hazard: stall persists with no counter change.

Test Plan:
1. Reset, then wb_en writes 0x1234_5678 to r5. Next cycle, decode R-type rs=5 rt=0 -> rd_data1=0x12345678, rd_data2=0, ex=1010, wb=10, out_valid=1 after one edge.
2. Bypass: same-cycle wb_en to r7 with value 0xDEADBEEF while decoding rs=7 -> rd_data1=0xDEADBEEF. Then write r0=0xFFFF_FFFF with ZERO_REG=1 -> a later read of r0 returns 0.
3. lw r3 followed by add using rs=3, out_ready=1, LU_BUBBLES=1 -> hazard_stall=1 for one cycle, EX sees exactly one out_valid=0 cycle, then add is accepted. Repeat with LU_BUBBLES=3 -> three bubble cycles.
4. Backpressure: out_ready=0 for 4 cycles -> in_ready=0 and outputs stable; on release, one instruction per cycle with no loss or duplication.
5. Opcode 0x3F -> illegal_op=1, all control 0, out_valid=1. lw with imm=0x8000 -> imm_ext=0xFFFF8000; imm=0x7FFF -> 0x00007FFF.
6. flush during bubble countdown -> out_valid=0 next edge, bubble_cnt=0. Assert rst low mid-stream -> all outputs 0 immediately and register file cleared.

Source files
------------

// File: rtl/decode_stage_pipelined.sv
// Instruction-decode stage: opcode decode, register file with write-through bypass,
// sign extension, ID/EX register, load-use bubble insertion and flush.
module decode_stage_pipelined #(
  parameter int WORD_W = 32,
  parameter int NUM_REGS = 32,
  localparam int REG_AW = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int LU_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [WORD_W-1:0] pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WORD_W-1:0] wb_data,
  output logic [3:0]        ex_ctrl,
  output logic [2:0]        mem_ctrl,
  output logic [1:0]        wb_ctrl,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] rd_data1,
  output logic [WORD_W-1:0] rd_data2,
  output logic [WORD_W-1:0] imm_ext,
  output logic [REG_AW-1:0] rs_out,
  output logic [REG_AW-1:0] rt_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              illegal_op,
  output logic              hazard_stall
);

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic       ZR     = (ZERO_REG != 0);

  function automatic logic [WORD_W-1:0] sext16(input logic [15:0] v);
    logic signed [15:0] s;
    s = signed'(v);
    return WORD_W'(s);
  endfunction

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs_idx, rt_idx, rd_idx;
  logic [3:0]        ex_dec;
  logic [2:0]        mem_dec;
  logic [1:0]        wb_dec;
  logic              ill_dec;
  logic              uses_rt;
  logic [WORD_W-1:0] regs [NUM_REGS];
  logic [WORD_W-1:0] rd1_p0, rd2_p0;
  logic              advance, in_fire;
  logic [2:0]        bub_cnt;

  logic              vld_p1;
  logic [3:0]        ex_ctrl_p1;
  logic [2:0]        mem_ctrl_p1;
  logic [1:0]        wb_ctrl_p1;
  logic [WORD_W-1:0] pc_p1, rd1_p1, rd2_p1, imm_p1;
  logic [REG_AW-1:0] rs_p1, rt_p1, rd_p1;
  logic              ill_p1;

  assign opcode = instruction[31:26];
  assign rs_idx = instruction[21 +: REG_AW];
  assign rt_idx = instruction[16 +: REG_AW];
  assign rd_idx = instruction[11 +: REG_AW];

  always_comb begin
    ex_dec  = '0;
    mem_dec = '0;
    wb_dec  = '0;
    ill_dec = 1'b0;
    case (opcode)
      OP_R:    begin ex_dec = 4'b1010; mem_dec = 3'b000; wb_dec = 2'b10; end
      OP_LW:   begin ex_dec = 4'b0100; mem_dec = 3'b100; wb_dec = 2'b11; end
      OP_SW:   begin ex_dec = 4'b0100; mem_dec = 3'b010; wb_dec = 2'b00; end
      OP_BEQ:  begin ex_dec = 4'b0001; mem_dec = 3'b001; wb_dec = 2'b00; end
      default: ill_dec = 1'b1;
    endcase
  end

  assign uses_rt = (opcode == OP_R) | (opcode == OP_SW) | (opcode == OP_BEQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && !(ZR && wb_addr == '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Zero-forcing wins over the same-cycle write-through path.
  assign rd1_p0 = (ZR && rs_idx == '0) ? '0 :
                  (wb_en && wb_addr == rs_idx) ? wb_data : regs[rs_idx];
  assign rd2_p0 = (ZR && rt_idx == '0) ? '0 :
                  (wb_en && wb_addr == rt_idx) ? wb_data : regs[rt_idx];

  assign hazard_stall = vld_p1 & mem_ctrl_p1[2] & in_valid
                      & (!ZR || rt_p1 != '0)
                      & ((rt_p1 == rs_idx) | (uses_rt & (rt_p1 == rt_idx)));

  assign advance  = ~vld_p1 | out_ready;
  assign in_ready = rst & advance & ~hazard_stall & (bub_cnt == 3'd0) & ~flush;
  assign in_fire  = in_valid & in_ready;

  // ID/EX boundary: control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      bub_cnt <= 3'd0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      bub_cnt <= 3'd0;
    end else begin
      if (advance) vld_p1 <= in_fire;
      if (bub_cnt != 3'd0) bub_cnt <= bub_cnt - 3'd1;
      else if (hazard_stall && out_ready) bub_cnt <= 3'(LU_BUBBLES - 1);
    end
  end

  // ID/EX boundary: data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_ctrl_p1  <= '0;
      mem_ctrl_p1 <= '0;
      wb_ctrl_p1  <= '0;
      pc_p1       <= '0;
      rd1_p1      <= '0;
      rd2_p1      <= '0;
      imm_p1      <= '0;
      rs_p1       <= '0;
      rt_p1       <= '0;
      rd_p1       <= '0;
      ill_p1      <= 1'b0;
    end else if (in_fire) begin
      ex_ctrl_p1  <= ex_dec;
      mem_ctrl_p1 <= mem_dec;
      wb_ctrl_p1  <= wb_dec;
      pc_p1       <= pc_in;
      rd1_p1      <= rd1_p0;
      rd2_p1      <= rd2_p0;
      imm_p1      <= sext16(instruction[15:0]);
      rs_p1       <= rs_idx;
      rt_p1       <= rt_idx;
      rd_p1       <= rd_idx;
      ill_p1      <= ill_dec;
    end
  end

  assign out_valid  = vld_p1;
  assign ex_ctrl    = ex_ctrl_p1;
  assign mem_ctrl   = mem_ctrl_p1;
  assign wb_ctrl    = wb_ctrl_p1;
  assign pc_out     = pc_p1;
  assign rd_data1   = rd1_p1;
  assign rd_data2   = rd2_p1;
  assign imm_ext    = imm_p1;
  assign rs_out     = rs_p1;
  assign rt_out     = rt_p1;
  assign rd_out     = rd_p1;
  assign illegal_op = ill_p1;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: one instance with LU_BUBBLES=1, one with 3.
module tb_decode_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid_b, out_ready, flush, wb_en;
  logic [31:0] instruction, pc_in, wb_data;
  logic [4:0]  wb_addr;

  logic        in_ready, out_valid, illegal_op, hazard_stall;
  logic [3:0]  ex_ctrl;
  logic [2:0]  mem_ctrl;
  logic [1:0]  wb_ctrl;
  logic [31:0] pc_out, rd_data1, rd_data2, imm_ext;
  logic [4:0]  rs_out, rt_out, rd_out;

  logic        in_ready_b, out_valid_b, illegal_op_b, hazard_stall_b;
  logic [3:0]  ex_ctrl_b;
  logic [2:0]  mem_ctrl_b;
  logic [1:0]  wb_ctrl_b;
  logic [31:0] pc_out_b, rd_data1_b, rd_data2_b, imm_ext_b;
  logic [4:0]  rs_out_b, rt_out_b, rd_out_b;

  int nvec = 0;
  int nmis = 0;
  int bub;

  always #5 clk = ~clk;

  decode_stage_pipelined #(.WORD_W(32), .NUM_REGS(32), .ZERO_REG(1), .LU_BUBBLES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .pc_out(pc_out),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .imm_ext(imm_ext),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .illegal_op(illegal_op), .hazard_stall(hazard_stall)
  );

  decode_stage_pipelined #(.WORD_W(32), .NUM_REGS(32), .ZERO_REG(1), .LU_BUBBLES(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .instruction(instruction), .pc_in(pc_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ctrl(ex_ctrl_b), .mem_ctrl(mem_ctrl_b), .wb_ctrl(wb_ctrl_b), .pc_out(pc_out_b),
    .rd_data1(rd_data1_b), .rd_data2(rd_data2_b), .imm_ext(imm_ext_b),
    .rs_out(rs_out_b), .rt_out(rt_out_b), .rd_out(rd_out_b),
    .illegal_op(illegal_op_b), .hazard_stall(hazard_stall_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h000};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0; out_ready = 1'b1; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; instruction = '0; pc_in = '0;

    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_rd_data1", rd_data1, 0);
    tick;
    rst = 1'b1;

    // write r5, then read it
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
    tick;
    wb_en = 1'b0; in_valid = 1'b1; instruction = rtype(5'd5, 5'd0, 5'd9); pc_in = 32'h100;
    #1 chk("t1_in_ready", in_ready, 1);
    tick;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_rd_data1", rd_data1, 32'h1234_5678);
    chk("t1_rd_data2", rd_data2, 0);
    chk("t1_ex_ctrl", ex_ctrl, 4'b1010);
    chk("t1_mem_ctrl", mem_ctrl, 3'b000);
    chk("t1_wb_ctrl", wb_ctrl, 2'b10);
    chk("t1_pc_out", pc_out, 32'h100);
    chk("t1_rd_out", rd_out, 9);
    chk("t1_illegal", illegal_op, 0);

    // same-cycle bypass and zero register
    instruction = rtype(5'd7, 5'd5, 5'd0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
    tick;
    chk("t2_bypass_rd1", rd_data1, 32'hDEAD_BEEF);
    chk("t2_rd2", rd_data2, 32'h1234_5678);
    wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; instruction = rtype(5'd0, 5'd7, 5'd0);
    tick;
    chk("t2_r0_no_bypass", rd_data1, 0);
    chk("t2_r7_stored", rd_data2, 32'hDEAD_BEEF);
    wb_en = 1'b0; instruction = rtype(5'd0, 5'd0, 5'd0);
    tick;
    chk("t2_r0_later", rd_data1, 0);

    // illegal opcode, sign extension, sw/beq decode
    instruction = {6'h3F, 26'h0};
    tick;
    chk("t5_illegal", illegal_op, 1);
    chk("t5_ill_ex", ex_ctrl, 0);
    chk("t5_ill_mem", mem_ctrl, 0);
    chk("t5_ill_wb", wb_ctrl, 0);
    chk("t5_ill_valid", out_valid, 1);
    instruction = itype(6'h23, 5'd0, 5'd4, 16'h8000);
    tick;
    chk("t5_lw_imm", imm_ext, 32'hFFFF_8000);
    chk("t5_lw_ex", ex_ctrl, 4'b0100);
    chk("t5_lw_mem", mem_ctrl, 3'b100);
    chk("t5_lw_wb", wb_ctrl, 2'b11);
    chk("t5_lw_legal", illegal_op, 0);
    instruction = itype(6'h2B, 5'd1, 5'd2, 16'h7FFF);
    #1 chk("t5_sw_no_hazard", hazard_stall, 0);
    tick;
    chk("t5_sw_imm", imm_ext, 32'h0000_7FFF);
    chk("t5_sw_mem", mem_ctrl, 3'b010);
    chk("t5_sw_wb", wb_ctrl, 2'b00);
    instruction = itype(6'h04, 5'd1, 5'd2, 16'h0000);
    tick;
    chk("t5_beq_ex", ex_ctrl, 4'b0001);
    chk("t5_beq_mem", mem_ctrl, 3'b001);
    in_valid = 1'b0;
    tick;
    chk("t5_drain", out_valid, 0);

    // load-use with one bubble
    in_valid = 1'b1; instruction = itype(6'h23, 5'd0, 5'd3, 16'h0);
    tick;
    chk("t3a_lw_valid", out_valid, 1);
    instruction = rtype(5'd3, 5'd0, 5'd8);
    #1;
    chk("t3a_hazard", hazard_stall, 1);
    chk("t3a_in_ready", in_ready, 0);
    bub = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_valid) break;
      bub++;
    end
    chk("t3a_bubbles", bub, 1);
    chk("t3a_add_rd", rd_out, 8);
    instruction = itype(6'h23, 5'd0, 5'd3, 16'h0);
    tick;
    instruction = itype(6'h23, 5'd1, 5'd3, 16'h0);
    #1 chk("t3a_lw_rt_no_hazard", hazard_stall, 0);
    instruction = rtype(5'd1, 5'd3, 5'd2);
    #1 chk("t3a_rt_hazard", hazard_stall, 1);
    in_valid = 1'b0;
    tick;
    tick;

    // load-use with three bubbles
    in_valid_b = 1'b1; instruction = itype(6'h23, 5'd0, 5'd3, 16'h0);
    tick;
    chk("t3b_lw_valid", out_valid_b, 1);
    instruction = rtype(5'd3, 5'd0, 5'd8);
    #1 chk("t3b_hazard", hazard_stall_b, 1);
    bub = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_valid_b) break;
      bub++;
    end
    in_valid_b = 1'b0;
    chk("t3b_bubbles", bub, 3);
    chk("t3b_add_rd", rd_out_b, 8);
    tick;

    // flush during bubble countdown
    in_valid_b = 1'b1; instruction = itype(6'h23, 5'd0, 5'd3, 16'h0);
    tick;
    instruction = rtype(5'd3, 5'd0, 5'd8);
    tick;
    chk("t6_countdown_in_ready", in_ready_b, 0);
    chk("t6_countdown_valid", out_valid_b, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    chk("t6_flush_valid", out_valid_b, 0);
    chk("t6_cnt_cleared", in_ready_b, 1);
    tick;
    chk("t6_after_flush_accept", out_valid_b, 1);
    in_valid_b = 1'b0;
    tick;

    // backpressure
    in_valid = 1'b1; instruction = rtype(5'd1, 5'd2, 5'd3); pc_in = 32'h200;
    tick;
    chk("t4_first", pc_out, 32'h200);
    out_ready = 1'b0; instruction = rtype(5'd1, 5'd2, 5'd4); pc_in = 32'h204;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_hold_in_ready", in_ready, 0);
      chk("t4_hold_pc", pc_out, 32'h200);
      chk("t4_hold_valid", out_valid, 1);
      tick;
    end
    out_ready = 1'b1;
    tick;
    chk("t4_b_pc", pc_out, 32'h204);
    chk("t4_b_rd", rd_out, 4);
    instruction = rtype(5'd1, 5'd2, 5'd5); pc_in = 32'h208;
    tick;
    chk("t4_c_pc", pc_out, 32'h208);
    instruction = rtype(5'd1, 5'd2, 5'd6); pc_in = 32'h20C;
    tick;
    chk("t4_d_pc", pc_out, 32'h20C);
    in_valid = 1'b0;
    tick;
    chk("t4_drain", out_valid, 0);

    // flush while EX stalls
    in_valid = 1'b1; instruction = rtype(5'd1, 5'd2, 5'd3); pc_in = 32'h300;
    tick;
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b0;
    tick;
    flush = 1'b0; out_ready = 1'b1;
    chk("t6_flush_stalled", out_valid, 0);

    // asynchronous reset mid-stream
    in_valid = 1'b1; instruction = rtype(5'd5, 5'd7, 5'd6); pc_in = 32'h400;
    tick;
    chk("t6_pre_rst_rd1", rd_data1, 32'h1234_5678);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_rd1", rd_data1, 0);
    chk("t6_rst_rd2", rd_data2, 0);
    chk("t6_rst_pc", pc_out, 0);
    chk("t6_rst_ex", ex_ctrl, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    tick;
    chk("t6_rst_no_accept", out_valid, 0);
    rst = 1'b1;
    tick;
    chk("t6_post_rst_valid", out_valid, 1);
    chk("t6_rf_cleared_r5", rd_data1, 0);
    chk("t6_rf_cleared_r7", rd_data2, 0);
    in_valid = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
